// File: rtl/rv32m_muldiv_ext_pkg.sv
// rtl/rv32m_muldiv_ext_pkg.sv - shared encodings, constants and helpers for the RV32M unit
package rv32m_muldiv_ext_pkg;

  // funct3 encodings of the M extension
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Divide special-case constants
  localparam logic [31:0] DIV_QUOT_DIVZERO = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_CALC,
    ST_DIV_FIX,
    ST_DONE
  } state_e;

  // Two's-complement negate when n is set
  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

  // Pick the architectural result for an instruction from its raw products
  function automatic logic [31:0] sel_result(input logic [2:0] f3, input logic [63:0] prod,
                                             input logic [31:0] quo, input logic [31:0] rem);
    case (f3)
      F3_MUL:                       return prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: return prod[63:32];
      F3_DIV, F3_DIVU:              return quo;
      F3_REM, F3_REMU:              return rem;
      default:                      return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv32m_muldiv_ext_divider.sv
// rtl/rv32m_muldiv_ext_divider.sv - unsigned iterative restoring divider, DIV_STEP bits per cycle
module rv32m_muldiv_ext_divider #(
  parameter int DIV_STEP = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        done_o
);

  localparam logic [5:0] ITER = 6'(32 / DIV_STEP);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q;
  logic [5:0]  cnt_q;
  logic [32:0] trial;

  // DIV_STEP restoring shift/subtract steps; quo_q doubles as the dividend shifter
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    trial = '0;
    for (int i = 0; i < DIV_STEP; i++) begin
      trial = {rem_d, quo_d[31]};
      quo_d = {quo_d[30:0], 1'b0};
      if (trial >= {1'b0, dsr_q}) begin
        trial    = trial - {1'b0, dsr_q};
        quo_d[0] = 1'b1;
      end
      rem_d = trial[31:0];
    end
  end

  // Load on start, then iterate while the countdown is non-zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dsr_q <= divisor_i;
      cnt_q <= ITER;
    end else if (cnt_q != 6'd0) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - 6'd1;
    end
  end

  // done marks the final iteration cycle; results are valid the cycle after
  assign done_o      = (cnt_q == 6'd1);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/rv32m_muldiv_ext.sv
// rtl/rv32m_muldiv_ext.sv - RV32M multiply/divide unit feeding the ALU external-update path
module rv32m_muldiv_ext
  import rv32m_muldiv_ext_pkg::*;
#(
  parameter int DIV_STEP = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a_decode,
  input  logic [31:0] b_decode,
  input  logic [4:0]  a_rs_idx,
  input  logic [4:0]  b_rs_idx,
  input  logic [4:0]  rd_in,
  input  logic [4:0]  regfile_rd_idx,
  input  logic [31:0] regfile_rd_val,
  input  logic        cancel,
  output logic        stall,
  output logic        extm_update_rd,
  output logic [4:0]  extm_rd_idx,
  output logic [31:0] extm_rd_val
);

  state_e      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q, idx_q;
  logic [31:0] a_q, b_q, res_q, val_q;
  logic        quot_neg_q, rem_neg_q;

  logic [31:0] a_op, b_op, a_mag, b_mag, spec_quo, spec_rem;
  logic [31:0] div_quo, div_rem;
  logic        accept, signed_div, a_neg, b_neg, div_zero, div_ovf, div_special, div_done;
  logic        a_sx, b_sx;
  logic [63:0] product;

  assign a_op = (a_rs_idx == regfile_rd_idx && regfile_rd_idx != 5'd0) ? regfile_rd_val : a_decode;
  assign b_op = (b_rs_idx == regfile_rd_idx && regfile_rd_idx != 5'd0) ? regfile_rd_val : b_decode;

  assign accept      = start & (state_q == ST_IDLE) & ~cancel & (rd_in != 5'd0);
  assign signed_div  = ~funct3[0];
  assign a_neg       = signed_div & a_op[31];
  assign b_neg       = signed_div & b_op[31];
  assign a_mag       = neg_if(a_neg, a_op);
  assign b_mag       = neg_if(b_neg, b_op);
  assign div_zero    = (b_op == 32'd0);
  assign div_ovf     = signed_div & (a_op == DIV_OVF_DIVIDEND) & (b_op == 32'hFFFF_FFFF);
  assign div_special = funct3[2] & (div_zero | div_ovf);
  assign spec_quo    = div_zero ? DIV_QUOT_DIVZERO : DIV_OVF_DIVIDEND;
  assign spec_rem    = div_zero ? a_op : 32'd0;

  // 33x33 signed product, truncated to 64 bits after explicit extension
  assign a_sx    = (funct3_q == F3_MULH || funct3_q == F3_MULHSU) & a_q[31];
  assign b_sx    = (funct3_q == F3_MULH) & b_q[31];
  assign product = {{32{a_sx}}, a_q} * {{32{b_sx}}, b_q};

  rv32m_muldiv_ext_divider #(.DIV_STEP(DIV_STEP)) u_divider (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (accept & funct3[2] & ~div_special),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quotient_o (div_quo),
    .remainder_o(div_rem),
    .done_o     (div_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake outputs; cancel overrides any busy state
  always_comb begin
    state_d        = state_q;
    stall          = accept | (state_q != ST_IDLE && state_q != ST_DONE);
    extm_update_rd = (state_q == ST_DONE) & ~cancel;
    case (state_q)
      ST_IDLE:     if (accept) state_d = !funct3[2] ? ST_MUL : (div_special ? ST_DONE : ST_DIV_CALC);
      ST_MUL:      state_d = ST_DONE;
      ST_DIV_CALC: if (div_done) state_d = ST_DIV_FIX;
      ST_DIV_FIX:  state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (cancel && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  // Operand latch, result register and held output values
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      funct3_q   <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      res_q      <= '0;
      idx_q      <= '0;
      val_q      <= '0;
    end else begin
      if (accept) begin
        funct3_q   <= funct3;
        rd_q       <= rd_in;
        a_q        <= a_op;
        b_q        <= b_op;
        quot_neg_q <= a_neg ^ b_neg;
        rem_neg_q  <= a_neg;
        if (div_special) res_q <= sel_result(funct3, 64'd0, spec_quo, spec_rem);
      end
      if (state_q == ST_MUL) res_q <= sel_result(funct3_q, product, 32'd0, 32'd0);
      if (state_q == ST_DIV_FIX)
        res_q <= sel_result(funct3_q, 64'd0, neg_if(quot_neg_q, div_quo), neg_if(rem_neg_q, div_rem));
      if (extm_update_rd) begin
        idx_q <= rd_q;
        val_q <= res_q;
      end
    end
  end

  assign extm_rd_idx = (state_q == ST_DONE) ? rd_q  : idx_q;
  assign extm_rd_val = (state_q == ST_DONE) ? res_q : val_q;

endmodule
